// File: rtl/gpio_pkg.sv
// Shared register map and CTRL layout for the GPIO port controller.
package gpio_pkg;

    localparam logic [2:0] GPIO_OFS_OUT_LO  = 3'd0;
    localparam logic [2:0] GPIO_OFS_OUT_HI  = 3'd1;
    localparam logic [2:0] GPIO_OFS_CTRL    = 3'd2;
    localparam logic [2:0] GPIO_OFS_IN_LO   = 3'd3;
    localparam logic [2:0] GPIO_OFS_IN_HI   = 3'd4;
    localparam logic [2:0] GPIO_OFS_EDGE_LO = 3'd5;
    localparam logic [2:0] GPIO_OFS_EDGE_HI = 3'd6;
    localparam logic [2:0] GPIO_OFS_RSVD    = 3'd7;

    localparam int GPIO_CTRL_T        = 0;
    localparam int GPIO_CTRL_IRQ_EN   = 1;
    localparam int GPIO_CTRL_ANY_EDGE = 2;

    localparam logic [7:0] GPIO_CTRL_RST = 8'h01;

    // W1C mask for a write to one of the EDGE registers; zero for any other offset.
    function automatic logic [15:0] gpio_w1c_mask(input logic [2:0] ofs, input logic [7:0] dat);
        logic [15:0] m;
        m = '0;
        if (ofs == GPIO_OFS_EDGE_LO) m = {8'h00, dat};
        if (ofs == GPIO_OFS_EDGE_HI) m = {dat, 8'h00};
        return m;
    endfunction

endpackage

// File: rtl/gpio_port_ctrl_if.sv
// KCPSM port bus: the CPU side is the master, the GPIO register block the slave.
interface gpio_port_ctrl_if;
    logic [7:0] port_id;
    logic       write_strobe;
    logic       read_strobe;
    logic [7:0] out_port;
    logic [7:0] in_port;
    logic       interrupt;

    modport master (output port_id, write_strobe, read_strobe, out_port,
                    input  in_port, interrupt);
    modport slave  (input  port_id, write_strobe, read_strobe, out_port,
                    output in_port, interrupt);
endinterface

// File: rtl/gpio_sync_edge.sv
// 2-flop pin synchronizer; with GPIO_EDGE_IRQ_EN also prev register, priming counter and edge detect.
// sync is 2 cycles behind the pins; edge_det is combinational on sync vs prev.
module gpio_sync_edge (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pins,
    output logic [15:0] sync
`ifdef GPIO_EDGE_IRQ_EN
    ,
    input  logic        any_edge,
    output logic [15:0] edge_det
`endif
);

    logic [15:0] meta_q, meta_d;
    logic [15:0] sync_q, sync_d;

    always_comb begin
        meta_d = pins;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sync = sync_q;

`ifdef GPIO_EDGE_IRQ_EN
    logic [15:0] prev_q, prev_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        primed_q, primed_d;
    logic [15:0] raw_edge;

    // primed rises on the third edge after reset, when prev finally holds real pin data.
    always_comb begin
        prev_d   = sync_q;
        cnt_d    = cnt_q;
        primed_d = primed_q;
        if (!primed_q) begin
            cnt_d    = cnt_q + 2'd1;
            primed_d = (cnt_q == 2'd2);
        end
        raw_edge = any_edge ? (sync_q ^ prev_q) : (sync_q & ~prev_q);
        edge_det = primed_q ? raw_edge : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q   <= '0;
            cnt_q    <= '0;
            primed_q <= 1'b0;
        end else begin
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
            primed_q <= primed_d;
        end
    end
`endif

endmodule

// File: rtl/gpio_port_ctrl.sv
// KCPSM port-mapped controller for a 16-bit tristate pin buffer; edge flags and interrupt only with GPIO_EDGE_IRQ_EN.
// in_port is registered (1 cycle after port_id); writes take effect on the strobe edge; no backpressure.
module gpio_port_ctrl
    import gpio_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'h10
) (
    input  logic             clk,
    input  logic             reset,
    gpio_port_ctrl_if.slave  bus,
    output logic [15:0]      gpio_i,
    output logic             gpio_t,
    input  logic [15:0]      gpio_o
);

`ifdef GPIO_EDGE_IRQ_EN
    localparam logic [7:0] CTRL_WMASK = 8'h07;
`else
    localparam logic [7:0] CTRL_WMASK = 8'h01;
`endif

    logic        hit, wr, rd_lo;
    logic [2:0]  ofs;
    logic [15:0] sync;

    logic [7:0]  lo_q, lo_d;
    logic [15:0] gpio_i_q, gpio_i_d;
    logic [7:0]  ctrl_q, ctrl_d;
    logic [7:0]  hi_snap_q, hi_snap_d;
    logic [7:0]  in_port_q, in_port_d;

    assign hit   = (bus.port_id[7:3] == BASE_ADDR[7:3]);
    assign ofs   = bus.port_id[2:0];
    assign wr    = bus.write_strobe & hit;
    assign rd_lo = bus.read_strobe & hit & (ofs == GPIO_OFS_IN_LO);

`ifdef GPIO_EDGE_IRQ_EN
    logic [15:0] edge_det;
    logic [15:0] flags_q, flags_d;
    logic        irq_q, irq_d;
    logic [15:0] clr_mask;

    gpio_sync_edge u_sync (
        .clk      (clk),
        .reset    (reset),
        .pins     (gpio_o),
        .sync     (sync),
        .any_edge (ctrl_q[GPIO_CTRL_ANY_EDGE]),
        .edge_det (edge_det)
    );

    // Set beats clear when a new edge and a W1C hit the same bit together.
    always_comb begin
        clr_mask = wr ? gpio_w1c_mask(ofs, bus.out_port) : '0;
        flags_d  = (flags_q & ~clr_mask) | edge_det;
        irq_d    = ctrl_q[GPIO_CTRL_IRQ_EN] & (|flags_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            irq_q   <= irq_d;
        end
    end

    assign bus.interrupt = irq_q;
`else
    gpio_sync_edge u_sync (
        .clk   (clk),
        .reset (reset),
        .pins  (gpio_o),
        .sync  (sync)
    );

    assign bus.interrupt = 1'b0;
`endif

    always_comb begin
        lo_d      = lo_q;
        gpio_i_d  = gpio_i_q;
        ctrl_d    = ctrl_q;
        hi_snap_d = hi_snap_q;
        in_port_d = '0;

        // OUT_HI commits both bytes at once so the pins never show a half-updated word.
        if (wr) begin
            case (ofs)
                GPIO_OFS_OUT_LO: lo_d     = bus.out_port;
                GPIO_OFS_OUT_HI: gpio_i_d = {bus.out_port, lo_q};
                GPIO_OFS_CTRL:   ctrl_d   = bus.out_port & CTRL_WMASK;
                default: ;
            endcase
        end

        if (rd_lo) hi_snap_d = sync[15:8];

        if (hit) begin
            case (ofs)
                GPIO_OFS_OUT_LO:  in_port_d = lo_q;
                GPIO_OFS_OUT_HI:  in_port_d = gpio_i_q[15:8];
                GPIO_OFS_CTRL:    in_port_d = ctrl_q;
                GPIO_OFS_IN_LO:   in_port_d = sync[7:0];
                GPIO_OFS_IN_HI:   in_port_d = hi_snap_q;
`ifdef GPIO_EDGE_IRQ_EN
                GPIO_OFS_EDGE_LO: in_port_d = flags_q[7:0];
                GPIO_OFS_EDGE_HI: in_port_d = flags_q[15:8];
`endif
                default:          in_port_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lo_q      <= '0;
            gpio_i_q  <= '0;
            ctrl_q    <= GPIO_CTRL_RST;
            hi_snap_q <= '0;
            in_port_q <= '0;
        end else begin
            lo_q      <= lo_d;
            gpio_i_q  <= gpio_i_d;
            ctrl_q    <= ctrl_d;
            hi_snap_q <= hi_snap_d;
            in_port_q <= in_port_d;
        end
    end

    assign gpio_i      = gpio_i_q;
    assign gpio_t      = ctrl_q[GPIO_CTRL_T];
    assign bus.in_port = in_port_q;

endmodule

// File: doc/gpio_port_ctrl.md
# gpio_port_ctrl

PicoBlaze port-mapped controller for the 16-bit tristate pin buffer. Drives the buffer's output data (`gpio_i`) and its single tristate enable (`gpio_t`), and samples the buffer's read-back (`gpio_o`) through a 2-flop synchronizer. Optionally flags pin edges and raises the processor interrupt. It sits between the KCPSM port bus and the pin buffer.

## Interface
- `BASE_ADDR`, default 8'h10: register block base. Decode is `port_id[7:3] == BASE_ADDR[7:3]`; the offset is `port_id[2:0]`.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `port_id` in 8: CPU port address.
- `write_strobe` in 1: CPU write qualifier, one cycle.
- `read_strobe` in 1: CPU read qualifier, one cycle.
- `out_port` in 8: CPU write data.
- `in_port` out 8: CPU read data, registered.
- `interrupt` out 1: level interrupt to the CPU.
- `gpio_i` out 16: data to the buffer's I.
- `gpio_t` out 1: buffer tristate enable; 1 = pins hi-Z (input mode).
- `gpio_o` in 16: buffer read-back. Equals the pins when `gpio_t`=1 and loopback of I when `gpio_t`=0.

## Operation
- Register offsets:
  - 0 OUT_LO (R/W)
  - 1 OUT_HI (R/W)
  - 2 CTRL (R/W): bit0 T, bit1 IRQ_EN, bit2 ANY_EDGE (0 = rising only), bits 7:3 read 0
  - 3 IN_LO (R)
  - 4 IN_HI (R)
  - 5 EDGE_LO (R/W1C)
  - 6 EDGE_HI (R/W1C)
  - 7 reserved: reads 0, writes ignored
- Atomic output write:
  - A write to OUT_LO loads the `lo_shadow` register only.
  - A write to OUT_HI loads `gpio_i[15:8]` from `out_port` and `gpio_i[7:0]` from `lo_shadow` in the same cycle.
  - Reading OUT_LO returns `lo_shadow`. Reading OUT_HI returns `gpio_i[15:8]`.
- Coherent input read:
  - A read of IN_LO (`read_strobe` with offset 3) returns `sync[7:0]` and captures `sync[15:8]` into `hi_snap`.
  - IN_HI returns `hi_snap`.
- A write to CTRL bit0 drives `gpio_t` directly from the next edge.
- Edge detect, per bit, on the synchronized value `s` against its previous value `p`:
  - rising: `s & ~p`
  - any: `s ^ p`
- Edge flags:
  - A detected edge sets the flag bit.
  - W1C clears the bits written as 1.
  - When a set and a clear hit the same bit in the same cycle, set wins.
- Edge detection is blocked while `primed`=0. A 2-bit counter after reset sets `primed` once the synchronizer has filled (3 edges), so pins already high at reset give no spurious flag.
- `interrupt` is registered: `IRQ_EN & |flags`. It is held until software clears the flags; `interrupt_ack` is not used.
- Writes or reads at addresses outside the block have no effect on it.

## Timing
- Reset values:
  - `gpio_i`=0, `lo_shadow`=0, `gpio_t`=1 (CTRL=8'h01)
  - `in_port`=0, `interrupt`=0
  - flags=0, sync/prev=0, `hi_snap`=0, `primed`=0
- `in_port` is a registered mux of the current `port_id`, updated every clock. It is valid 1 cycle after `port_id`, which meets KCPSM's 2-cycle INPUT timing.
- Write side effects occur on the edge where `write_strobe`=1.
- Pin to IN register: 2 cycles of sync, then 1 cycle of `in_port` register.
- Pin edge to flag: 3 cycles. Flag to `interrupt`: 1 further cycle.
- When `reset` is asserted mid-transaction, all state returns to reset values asynchronously and the pins go hi-Z immediately.

## Configuration
- `GPIO_EDGE_IRQ_EN` defined: the edge logic, flags, `primed` counter and interrupt are present.
- `GPIO_EDGE_IRQ_EN` undefined:
  - Offsets 5 and 6 read 0.
  - CTRL bits 1 and 2 read 0 and writes to them are ignored.
  - `interrupt` is tied to 0.
  - The synchronizer and coherent-read logic remain.

## Structure
- Shared package `gpio_pkg` holds:
  - the offset constants `GPIO_OFS_*`
  - the CTRL bit indices `GPIO_CTRL_T`, `GPIO_CTRL_IRQ_EN`, `GPIO_CTRL_ANY_EDGE`
  - the reset constant `GPIO_CTRL_RST` = 8'h01
- Sub-module `gpio_sync_edge` contains:
  - the 16-bit 2-flop synchronizer
  - the prev register and `primed` counter
  - edge-detect outputs `sync[15:0]` and `edge[15:0]`

## Test plan
- Reset, then read CTRL -> 8'h01. Check `gpio_t`=1, `gpio_i`=0, `interrupt`=0.
- Write OUT_LO=8'hA5 -> `gpio_i` stays 0. Then write OUT_HI=8'h3C -> `gpio_i`=16'h3CA5 on a single edge. Then write CTRL=0 -> `gpio_t`=0.
- `gpio_o`=16'h1234, wait 3 cycles, read IN_LO -> 8'h34. Change `gpio_o` to 16'hFFFF, then read IN_HI -> 8'h12 (the snapshot).
- CTRL=8'h03 and `gpio_o` bit9 goes 0->1 -> EDGE_HI=8'h02, and `interrupt`=1 four cycles after the pin change. W1C 8'h02 to EDGE_HI -> `interrupt`=0.
- `gpio_o`=16'hFFFF held through reset release -> no flags set. A new rising edge on bit0 coincident with a W1C of bit0 -> flag remains 1.
- Build without `GPIO_EDGE_IRQ_EN` -> toggling pins leaves `interrupt`=0, and offsets 5 and 6 read 8'h00.
